// File: rtl/spi_subunit_sync.sv
// SPI peripheral-side subunit. sclk/cs/mosi are oversampled in the clk domain,
// all four CPOL/CPHA modes, valid/ready transmit holding register and a
// single-cycle receive strobe. Back-to-back words within one cs are supported.
module spi_subunit_sync #(
  parameter int DATA_WIDTH  = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  tx_underrun
);

  localparam int   CW     = $clog2(DATA_WIDTH + 1);
  localparam logic L_IDLE = logic'(CPOL != 0);
  localparam logic L_CPHA = logic'(CPHA != 0);

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [SYNC_STAGES-1:0]  r_sclk_sync;
  logic [SYNC_STAGES-1:0]  r_cs_sync;
  logic [SYNC_STAGES-1:0]  r_mosi_sync;
  logic                    r_sclk_prev;
  logic                    r_cs_prev;
  logic [CW-1:0]           r_count;
  logic [DATA_WIDTH-1:0]   r_rx_shift;
  logic [DATA_WIDTH-1:0]   r_tx_shift;
  logic [DATA_WIDTH-1:0]   r_rx_data;
  logic                    r_rx_valid;
  logic                    r_tx_underrun;
  logic                    r_word_done;
  logic [DATA_WIDTH-1:0]   r_hold;
  logic                    r_hold_full;

  logic w_sclk_s, w_cs_s, w_mosi_s;
  logic w_sclk_rise, w_sclk_fall, w_lead, w_trail, w_sample, w_drive;
  logic w_cs_fall, w_cs_rise;
  logic w_start, w_stop, w_sample_en, w_shift, w_load, w_accept;

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_prev;
  assign w_sclk_fall = ~w_sclk_s & r_sclk_prev;
  assign w_lead      = L_IDLE ? w_sclk_fall : w_sclk_rise;
  assign w_trail     = L_IDLE ? w_sclk_rise : w_sclk_fall;
  assign w_sample    = L_CPHA ? w_trail : w_lead;
  assign w_drive     = L_CPHA ? w_lead : w_trail;
  assign w_cs_fall   = r_cs_prev & ~w_cs_s;
  assign w_cs_rise   = ~r_cs_prev & w_cs_s;
  assign w_accept    = tx_valid & ~r_hold_full;

  // Input synchronizers plus one extra sample of sclk/cs for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_sync <= {SYNC_STAGES{L_IDLE}};
      r_cs_sync   <= {SYNC_STAGES{1'b1}};
      r_mosi_sync <= '0;
      r_sclk_prev <= L_IDLE;
      r_cs_prev   <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_sclk_prev <= w_sclk_s;
      r_cs_prev   <= w_cs_s;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and per-cycle actions; a cs edge always takes priority over sclk
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_stop      = 1'b0;
    w_sample_en = 1'b0;
    w_shift     = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt = ST_ACTIVE;
          w_start     = 1'b1;
          w_load      = ~L_CPHA;
        end
      end
      ST_ACTIVE: begin
        if (w_cs_rise) begin
          w_state_nxt = ST_IDLE;
          w_stop      = 1'b1;
        end else if (w_sample) begin
          w_sample_en = 1'b1;
        end else if (w_drive) begin
          if (r_count == '0 && (L_CPHA || r_word_done)) w_load  = 1'b1;
          else                                          w_shift = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Holding register, shift registers, bit counter and receive/underrun strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count       <= '0;
      r_rx_shift    <= '0;
      r_tx_shift    <= '0;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_tx_underrun <= 1'b0;
      r_word_done   <= 1'b0;
      r_hold        <= '0;
      r_hold_full   <= 1'b0;
    end else begin
      r_rx_valid    <= 1'b0;
      r_tx_underrun <= 1'b0;
      if (w_load) begin
        r_tx_shift    <= r_hold_full ? r_hold : '0;
        r_tx_underrun <= ~r_hold_full;
        r_hold_full   <= 1'b0;
      end
      if (w_accept) begin
        r_hold      <= tx_data;
        r_hold_full <= 1'b1;
      end
      if (w_shift) r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
      if (w_start) begin
        r_count     <= '0;
        r_word_done <= 1'b0;
        r_rx_shift  <= '0;
      end
      if (w_stop) begin
        r_count    <= '0;
        r_rx_shift <= '0;
        r_tx_shift <= '0;
      end
      if (w_sample_en) begin
        r_rx_shift <= {r_rx_shift[DATA_WIDTH-2:0], w_mosi_s};
        if (r_count == CW'(DATA_WIDTH - 1)) begin
          r_rx_data   <= {r_rx_shift[DATA_WIDTH-2:0], w_mosi_s};
          r_rx_valid  <= 1'b1;
          r_count     <= '0;
          r_word_done <= 1'b1;
        end else begin
          r_count <= r_count + CW'(1);
        end
      end
    end
  end

  assign busy        = (r_state == ST_ACTIVE);
  assign miso_oe     = busy;
  assign miso        = busy & r_tx_shift[DATA_WIDTH-1];
  assign tx_ready    = ~r_hold_full;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign tx_underrun = r_tx_underrun;

endmodule

// File: tb/tb_spi_subunit_sync.sv
// Bench for spi_subunit_sync: four 8-bit instances (modes 0..3) and one 16-bit
// mode-0 instance, each driven by a behavioural SPI controller task.
module tb_spi_subunit_sync;

  localparam int H = 8;  // clk cycles per sclk half period

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  sclk, cs, mosi, miso, miso_oe, tx_valid, tx_ready, rx_valid, busy, tx_underrun;
  logic [7:0]  tx_data8 [4];
  logic [7:0]  rx_data8 [4];
  logic [15:0] tx_data16, rx_data16;

  int          n_vec = 0;
  int          n_err = 0;
  int          rvc [5] = '{default: 0};
  int          urc [5] = '{default: 0};
  logic [15:0] rx_last [5];
  logic [7:0]  log0 [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_m
    spi_subunit_sync #(.DATA_WIDTH(8), .CPOL(g / 2), .CPHA(g % 2), .SYNC_STAGES(2)) u_dut (
      .clk(clk), .rst(rst), .sclk(sclk[g]), .cs(cs[g]), .mosi(mosi[g]),
      .miso(miso[g]), .miso_oe(miso_oe[g]), .tx_data(tx_data8[g]), .tx_valid(tx_valid[g]),
      .tx_ready(tx_ready[g]), .rx_data(rx_data8[g]), .rx_valid(rx_valid[g]),
      .busy(busy[g]), .tx_underrun(tx_underrun[g])
    );
  end

  spi_subunit_sync #(.DATA_WIDTH(16), .CPOL(0), .CPHA(0), .SYNC_STAGES(2)) u_dut16 (
    .clk(clk), .rst(rst), .sclk(sclk[4]), .cs(cs[4]), .mosi(mosi[4]),
    .miso(miso[4]), .miso_oe(miso_oe[4]), .tx_data(tx_data16), .tx_valid(tx_valid[4]),
    .tx_ready(tx_ready[4]), .rx_data(rx_data16), .rx_valid(rx_valid[4]),
    .busy(busy[4]), .tx_underrun(tx_underrun[4])
  );

  // Receive / underrun event monitor
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rx_valid[i]) begin
        rx_last[i] = {8'h00, rx_data8[i]};
        if (i == 0) log0[rvc[0] % 4] = rx_data8[0];
        rvc[i]++;
      end
      if (tx_underrun[i]) urc[i]++;
    end
    if (rx_valid[4]) begin
      rx_last[4] = rx_data16;
      rvc[4]++;
    end
    if (tx_underrun[4]) urc[4]++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One sclk half period; counts miso changes during the last cycles before the edge
  task automatic half(input int idx, output logic s, inout int un);
    logic v;
    v = 1'b0;
    for (int c = 0; c < H; c++) begin
      @(negedge clk);
      if (c == H - 3) v = miso[idx];
      else if (c > H - 3 && miso[idx] !== v) un++;
    end
    s = miso[idx];
  endtask

  task automatic push(input int idx, input logic [15:0] d);
    @(negedge clk);
    if (idx == 4) tx_data16 = d;
    else          tx_data8[idx] = d[7:0];
    tx_valid[idx] = 1'b1;
    @(negedge clk);
    tx_valid[idx] = 1'b0;
  endtask

  // Controller-side transfer of nbits MSB first; stop>0 ends after stop clocks, leaving cs low
  task automatic xfer(input int idx, input bit cpol, input bit cpha, input int nbits,
                      input logic [31:0] mo, input int stop,
                      output logic [31:0] mi, output int un);
    int   nb;
    logic s;
    nb = (stop > 0) ? stop : nbits;
    mi = '0;
    un = 0;
    cs[idx] = 1'b0;
    if (!cpha) mosi[idx] = mo[nbits-1];
    for (int i = 0; i < nb; i++) begin
      if (!cpha) begin
        half(idx, s, un);
        mi = {mi[30:0], s};
        sclk[idx] = ~cpol;
        half(idx, s, un);
        sclk[idx] = cpol;
        if (i + 1 < nbits) mosi[idx] = mo[nbits-2-i];
      end else begin
        half(idx, s, un);
        sclk[idx] = ~cpol;
        mosi[idx] = mo[nbits-1-i];
        half(idx, s, un);
        mi = {mi[30:0], s};
        sclk[idx] = cpol;
      end
    end
    if (stop == 0) begin
      half(idx, s, un);
      cs[idx] = 1'b1;
      half(idx, s, un);
    end
  endtask

  initial begin
    logic [31:0] mi;
    int          un, base, ubase;
    rst = 1'b1;
    cs = '1;
    mosi = '0;
    tx_valid = '0;
    sclk = 5'b01100;
    tx_data16 = '0;
    for (int i = 0; i < 4; i++) tx_data8[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctl_m3", 32'({tx_ready[3], miso[3], miso_oe[3], busy[3], rx_valid[3], tx_underrun[3]}), 32'h20);
    chk("rst_rx_m3", 32'(rx_data8[3]), 32'h0);
    chk("rst_ctl_w16", 32'({tx_ready[4], miso[4], miso_oe[4], busy[4], rx_valid[4], tx_underrun[4]}), 32'h20);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // single-word exchange in every mode
    for (int m = 0; m < 4; m++) begin
      push(m, (m == 0) ? 16'h00A5 : 16'h005A);
      base = rvc[m];
      xfer(m, m[1], m[0], 8, (m == 0) ? 32'h3C : 32'hC3, 0, mi, un);
      chk($sformatf("miso_m%0d", m), mi, (m == 0) ? 32'hA5 : 32'h5A);
      chk($sformatf("rxcnt_m%0d", m), 32'(rvc[m] - base), 32'd1);
      chk($sformatf("rx_m%0d", m), 32'(rx_last[m]), (m == 0) ? 32'h3C : 32'hC3);
      chk($sformatf("stable_m%0d", m), 32'(un), 32'd0);
      if (m == 0) chk("txrdy_m0", 32'(tx_ready[0]), 32'd1);
    end

    // back-to-back words under one cs, holding register refilled on demand
    push(0, 16'h0011);
    base = rvc[0];
    fork
      xfer(0, 1'b0, 1'b0, 24, 32'hDEAD42, 0, mi, un);
      begin
        logic [7:0] vals [2];
        vals[0] = 8'h22;
        vals[1] = 8'h33;
        for (int k = 0; k < 2; k++) begin
          int t;
          t = 0;
          @(negedge clk);
          while (!tx_ready[0] && t < 400) begin
            @(negedge clk);
            t++;
          end
          chk("feed_wait", 32'(t < 400), 32'd1);
          tx_data8[0] = vals[k];
          tx_valid[0] = 1'b1;
          @(negedge clk);
          tx_valid[0] = 1'b0;
        end
      end
    join
    chk("b2b_miso", mi, 32'h112233);
    chk("b2b_rxcnt", 32'(rvc[0] - base), 32'd3);
    chk("b2b_rx0", 32'(log0[base % 4]), 32'hDE);
    chk("b2b_rx1", 32'(log0[(base + 1) % 4]), 32'hAD);
    chk("b2b_rx2", 32'(log0[(base + 2) % 4]), 32'h42);
    chk("b2b_stable", 32'(un), 32'd0);

    // abort mid-word, then a clean transfer
    base = rvc[0];
    xfer(0, 1'b0, 1'b0, 8, 32'h55, 5, mi, un);
    chk("abort_busy_pre", 32'(busy[0]), 32'd1);
    cs[0] = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_oe_busy", 32'({miso_oe[0], busy[0]}), 32'd0);
    repeat (H) @(negedge clk);
    chk("abort_rxcnt", 32'(rvc[0] - base), 32'd0);
    push(0, 16'h0096);
    xfer(0, 1'b0, 1'b0, 8, 32'h69, 0, mi, un);
    chk("post_abort_miso", mi, 32'h96);
    chk("post_abort_rx", 32'(rx_last[0]), 32'h69);

    // underrun (mode 1: a single load per word)
    ubase = urc[1];
    xfer(1, 1'b0, 1'b1, 8, 32'hFF, 0, mi, un);
    chk("undr_miso", mi, 32'h00);
    chk("undr_cnt", 32'(urc[1] - ubase), 32'd1);
    chk("undr_rx", 32'(rx_last[1]), 32'hFF);

    // 16-bit instance: transfer, async reset mid-word, transfer
    push(4, 16'h1357);
    xfer(4, 1'b0, 1'b0, 16, 32'hCAFE, 0, mi, un);
    chk("w16_miso", mi, 32'h1357);
    chk("w16_rx", 32'(rx_last[4]), 32'hCAFE);
    xfer(4, 1'b0, 1'b0, 16, 32'h1234, 6, mi, un);
    push(4, 16'h5555);
    chk("w16_pre_rst", 32'({tx_ready[4], busy[4], miso_oe[4]}), 32'h3);
    base = rvc[4];
    #1 rst = 1'b1;
    #2;
    chk("w16_rst_ctl", 32'({tx_ready[4], miso[4], miso_oe[4], busy[4], rx_valid[4], tx_underrun[4]}), 32'h20);
    chk("w16_rst_rx", 32'(rx_data16), 32'h0);
    @(negedge clk);
    cs[4] = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("w16_rst_rxcnt", 32'(rvc[4] - base), 32'd0);
    push(4, 16'h600D);
    xfer(4, 1'b0, 1'b0, 16, 32'hBEEF, 0, mi, un);
    chk("w16_beef_miso", mi, 32'h600D);
    chk("w16_beef_rx", 32'(rx_last[4]), 32'hBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
